// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, functs, FSM states, ALU modes.
package mc_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  // R-type words with a nonzero shamt are reserved encodings and trap.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct,
                                    input logic [4:0] shamt);
    case (op)
      OP_RTYPE: return (shamt == 5'd0) &&
                       (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, r0 reads 0.
module mc_regfile (
  input  logic        clock,
  input  logic        nreset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] regs [32];

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle MIPS-I subset core sharing one req/ready memory port for fetch and data.
module mc_cpu
  import mc_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter int          ADDR_W            = 32,
  parameter bit          TRAP_ON_UNALIGNED = 1'b1
) (
  input  logic              clock,
  input  logic              nreset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              retire,
  output logic              halted
);

  state_t      state;
  logic [31:0] ir, a_q, b_q, tgt, alu_out, mdr;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_ext, rf_a, rf_b, alu_b, alu_result, bus_addr;
  logic [3:0]  alu_mode;

  assign op      = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign shamt   = ir[10:6];
  assign funct   = ir[5:0];
  assign imm_ext = sext16(ir[15:0]);

  mc_regfile u_regfile (
    .clock   (clock),
    .nreset  (nreset),
    .we      (state == WB),
    .waddr   ((op == OP_RTYPE) ? rd : rt),
    .wdata   ((op == OP_LW) ? mdr : alu_out),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  always_comb begin
    alu_mode = ALU_ADD;
    if (op == OP_RTYPE) begin
      case (funct)
        FN_SUB:  alu_mode = ALU_SUB;
        FN_AND:  alu_mode = ALU_AND;
        FN_OR:   alu_mode = ALU_OR;
        FN_SLT:  alu_mode = ALU_SLT;
        default: alu_mode = ALU_ADD;
      endcase
    end
  end

  assign alu_b = (op == OP_RTYPE) ? b_q : imm_ext;

  always_comb begin
    alu_result = a_q + alu_b;
    case (alu_mode)
      ALU_SUB: alu_result = a_q - alu_b;
      ALU_AND: alu_result = a_q & alu_b;
      ALU_OR:  alu_result = a_q | alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(a_q) < $signed(alu_b)};
      default: alu_result = a_q + alu_b;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tgt     <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            pc    <= pc + 32'd4;
            state <= DECODE;
          end
        end
        DECODE: begin
          a_q   <= rf_a;
          b_q   <= rf_b;
          tgt   <= pc + (imm_ext << 2);
          state <= is_legal(op, funct, shamt) ? EXEC : TRAP;
        end
        EXEC: begin
          case (op)
            OP_BEQ: begin
              if (a_q == b_q) pc <= tgt;
              state <= FETCH;
            end
            OP_J: begin
              pc    <= {pc[31:28], ir[25:0], 2'b00};
              state <= FETCH;
            end
            // With trapping disabled the low address bits are simply dropped.
            OP_LW, OP_SW: begin
              alu_out <= {alu_result[31:2], 2'b00};
              if (TRAP_ON_UNALIGNED && (alu_result[1:0] != 2'b00)) state <= TRAP;
              else                                                   state <= MEM;
            end
            default: begin
              alu_out <= alu_result;
              state   <= WB;
            end
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            if (op == OP_SW) begin
              state <= FETCH;
            end else begin
              mdr   <= mem_rdata;
              state <= WB;
            end
          end
        end
        WB:      state <= FETCH;
        TRAP:    state <= TRAP;
        default: state <= TRAP;
      endcase
    end
  end

  // Bus outputs are gated by nreset so a falling reset kills an in-flight store at once.
  assign bus_addr  = (state == MEM) ? alu_out : pc;
  assign mem_addr  = bus_addr[ADDR_W-1:0];
  assign mem_req   = nreset && ((state == FETCH) || (state == MEM));
  assign mem_we    = nreset && (state == MEM) && (op == OP_SW);
  assign mem_wdata = b_q;
  assign halted    = (state == TRAP);
  assign retire    = nreset && (((state == EXEC) && ((op == OP_BEQ) || (op == OP_J))) ||
                                ((state == MEM) && (op == OP_SW) && mem_ready) ||
                                (state == WB));

endmodule

// File: tb/tb_mc_cpu.sv
// Directed bench for mc_cpu: RAM model with programmable wait states, retire/bus logging.
module tb_mc_cpu;
  import mc_cpu_pkg::*;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  logic [31:0] mem [1024];
  int          wait_cycles = 0;
  int          wcnt = 0;
  logic [31:0] cycle = '0;

  int tests = 0;
  int fails = 0;

  logic [31:0] retire_log [$];
  logic [31:0] rd_addr [$];
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];

  logic        hold_pending = 1'b0;
  logic [65:0] prev_bus = '0;

  mc_cpu #(
    .RESET_PC          (32'h0000_0100),
    .ADDR_W            (32),
    .TRAP_ON_UNALIGNED (1'b1)
  ) dut (
    .clock     (clock),
    .nreset    (nreset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .retire    (retire),
    .halted    (halted)
  );

  always #5 clock = ~clock;

  // RAM model: ready rises after wait_cycles cycles of continuous request.
  assign mem_ready = mem_req && (wcnt >= wait_cycles);
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clock) begin
    cycle <= cycle + 32'd1;
    if (mem_req && mem_ready && mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    if (!mem_req || mem_ready) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (retire) retire_log.push_back(cycle);
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
      end else begin
        rd_addr.push_back(mem_addr);
      end
    end
    if (hold_pending && nreset) begin
      tests++;
      assert ({mem_req, mem_we, mem_addr, mem_wdata} === prev_bus) else begin
        fails++;
        $error("[TB] FAIL req_stable: observed %h expected %h",
               {mem_req, mem_we, mem_addr, mem_wdata}, prev_bus);
      end
    end
    hold_pending = mem_req && !mem_ready && nreset;
    prev_bus     = {mem_req, mem_we, mem_addr, mem_wdata};
  end

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 32'hBAAD_F00D;
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic load(input logic [31:0] addr, input logic [31:0] word);
    mem[addr[11:2]] <= word;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Enter reset, wipe memory and logs, set the wait-state count for the next program.
  task automatic apply_reset(input int waits);
    nreset = 1'b0;
    wait_cycles = waits;
    for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
    retire_log.delete();
    rd_addr.delete();
    wr_addr.delete();
    wr_data.delete();
    tick(3);
  endtask

  task automatic wait_halted(input int budget, input string tag);
    for (int i = 0; i < budget && !halted; i++) @(negedge clock);
    check_output(tag, {31'd0, halted}, 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : apply_stimulus
    // Arithmetic program, zero-wait memory, ends on an illegal opcode.
    apply_reset(0);
    load(32'h100, enc_i(OP_ADDI, 0, 1, 16'd5));
    load(32'h104, enc_i(OP_ADDI, 0, 2, 16'hFFFD));
    load(32'h108, enc_r(1, 2, 3, FN_ADD));
    load(32'h10C, enc_r(2, 1, 4, FN_SLT));
    load(32'h110, enc_i(OP_SW, 0, 3, 16'h0200));
    load(32'h114, enc_i(OP_SW, 0, 4, 16'h0204));
    load(32'h118, 32'hFC00_0000);
    tick(1);
    check_output("rst_pc", pc, 32'h100);
    check_output("rst_req", {31'd0, mem_req}, 32'd0);
    check_output("rst_we", {31'd0, mem_we}, 32'd0);
    check_output("rst_halted", {31'd0, halted}, 32'd0);
    check_output("rst_retire", {31'd0, retire}, 32'd0);
    nreset = 1'b1;
    #1;
    check_output("first_req", {31'd0, mem_req}, 32'd1);
    check_output("first_addr", mem_addr, 32'h100);
    wait_halted(200, "p1_halted");
    check_output("p1_retires", retire_log.size(), 32'd6);
    check_output("p1_gap_addi", q_at(retire_log, 1) - q_at(retire_log, 0), 32'd4);
    check_output("p1_gap_add", q_at(retire_log, 2) - q_at(retire_log, 1), 32'd4);
    check_output("p1_gap_slt", q_at(retire_log, 3) - q_at(retire_log, 2), 32'd4);
    check_output("p1_gap_sw", q_at(retire_log, 4) - q_at(retire_log, 3), 32'd4);
    check_output("p1_writes", wr_addr.size(), 32'd2);
    check_output("p1_w0_addr", q_at(wr_addr, 0), 32'h200);
    check_output("p1_add_r3", q_at(wr_data, 0), 32'd2);
    check_output("p1_w1_addr", q_at(wr_addr, 1), 32'h204);
    check_output("p1_slt_r4", q_at(wr_data, 1), 32'd1);
    tick(5);
    check_output("trap_no_retire", retire_log.size(), 32'd6);
    check_output("trap_req", {31'd0, mem_req}, 32'd0);
    check_output("trap_pc", pc, 32'h11C);

    // Store/load round trip with two wait states per transaction.
    apply_reset(2);
    load(32'h100, enc_i(OP_ADDI, 0, 1, 16'd5));
    load(32'h104, enc_i(OP_SW, 0, 1, 16'd8));
    load(32'h108, enc_i(OP_LW, 0, 5, 16'd8));
    load(32'h10C, enc_i(OP_SW, 0, 5, 16'h020C));
    load(32'h110, 32'hFC00_0000);
    load(32'h008, 32'h0000_DEAD);
    tick(1);
    nreset = 1'b1;
    wait_halted(400, "p2_halted");
    check_output("p2_retires", retire_log.size(), 32'd4);
    check_output("p2_sw_cycles", q_at(retire_log, 1) - q_at(retire_log, 0), 32'd8);
    check_output("p2_lw_cycles", q_at(retire_log, 2) - q_at(retire_log, 1), 32'd9);
    check_output("p2_w0_addr", q_at(wr_addr, 0), 32'h008);
    check_output("p2_w0_data", q_at(wr_data, 0), 32'd5);
    check_output("p2_w1_addr", q_at(wr_addr, 1), 32'h20C);
    check_output("p2_lw_r5", q_at(wr_data, 1), 32'd5);

    // Control flow: taken beq, untaken beq, jump back to 0x100.
    apply_reset(0);
    load(32'h100, enc_i(OP_ADDI, 0, 1, 16'd1));
    load(32'h104, enc_i(OP_BEQ, 0, 0, 16'd2));
    load(32'h108, 32'hFC00_0000);
    load(32'h10C, 32'hFC00_0000);
    load(32'h110, enc_i(OP_BEQ, 0, 1, 16'd5));
    load(32'h114, {OP_J, 26'h40});
    tick(1);
    nreset = 1'b1;
    for (int i = 0; i < 100 && rd_addr.size() < 6; i++) @(negedge clock);
    check_output("p3_no_trap", {31'd0, halted}, 32'd0);
    check_output("p3_f0", q_at(rd_addr, 0), 32'h100);
    check_output("p3_f1", q_at(rd_addr, 1), 32'h104);
    check_output("p3_beq_taken", q_at(rd_addr, 2), 32'h110);
    check_output("p3_beq_not", q_at(rd_addr, 3), 32'h114);
    check_output("p3_j_target", q_at(rd_addr, 4), 32'h100);
    check_output("p3_f5", q_at(rd_addr, 5), 32'h104);
    check_output("p3_beq_cycles", q_at(retire_log, 1) - q_at(retire_log, 0), 32'd3);
    check_output("p3_j_cycles", q_at(retire_log, 3) - q_at(retire_log, 2), 32'd3);

    // Unaligned load traps before any data access.
    apply_reset(0);
    load(32'h100, enc_i(OP_LW, 0, 5, 16'd6));
    load(32'h104, enc_i(OP_ADDI, 0, 1, 16'd1));
    tick(1);
    nreset = 1'b1;
    wait_halted(50, "p4_halted");
    tick(3);
    check_output("p4_retires", retire_log.size(), 32'd0);
    check_output("p4_reads", rd_addr.size(), 32'd1);
    check_output("p4_writes", wr_addr.size(), 32'd0);
    check_output("p4_pc", pc, 32'h104);

    // Reset while a store waits in MEM: no write, restart at RESET_PC.
    apply_reset(3);
    load(32'h100, enc_i(OP_ADDI, 0, 1, 16'd7));
    load(32'h104, enc_i(OP_SW, 0, 1, 16'h0300));
    load(32'h300, 32'h0000_CAFE);
    tick(1);
    nreset = 1'b1;
    for (int i = 0; i < 100 && !(mem_req && mem_we); i++) @(negedge clock);
    check_output("p5_store_seen", {31'd0, mem_we}, 32'd1);
    tick(1);
    nreset = 1'b0;
    #1;
    check_output("p5_abort_req", {31'd0, mem_req}, 32'd0);
    check_output("p5_abort_we", {31'd0, mem_we}, 32'd0);
    check_output("p5_abort_pc", pc, 32'h100);
    tick(3);
    check_output("p5_no_write", wr_addr.size(), 32'd0);
    check_output("p5_mem_kept", mem[32'h300 >> 2], 32'h0000_CAFE);
    wait_cycles = 0;
    rd_addr.delete();
    nreset = 1'b1;
    #1;
    check_output("p5_refetch_addr", mem_addr, 32'h100);
    tick(1);
    check_output("p5_refetch_done", q_at(rd_addr, 0), 32'h100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_cpu.md
Name: mc_cpu

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS core.
- Executes the MIPS-I subset over one shared instruction/data memory port with a req/ready handshake, so memories may insert wait states.
- Adds configurable reset vector, memory wait-state tolerance, alignment/illegal-opcode trap, and a retire strobe for bench scoreboarding.
- Sits between the testbench/SoC top and a single RAM model.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, width of mem_addr; low ADDR_W bits of the byte address are driven.
- TRAP_ON_UNALIGNED, 1, 1 = unaligned lw/sw traps; 0 = low two address bits are forced to 0.

Ports:
- clock  in  1  system clock, rising edge.
- nreset  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, valid while mem_req.
- mem_addr  out  ADDR_W  byte address, word aligned.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  load/fetch data, valid when mem_ready.
- mem_ready  in  1  transaction completes on the rising edge where mem_req && mem_ready.
- pc  out  32  architectural PC.
- retire  out  1  one-cycle pulse when an instruction commits.
- halted  out  1  core is in TRAP.

Behaviour:
- Reset (async, nreset=0): state=FETCH, pc=RESET_PC, IR=0, all registers in the register file=0. Outputs during reset: mem_req=0, mem_we=0, retire=0, halted=0.
- Instruction subset:
  - R-type funct: add, sub, and, or, slt.
  - addi, lw, sw, beq, j.
  - Any other opcode or funct traps.
- State FETCH: mem_req=1, mem_we=0, mem_addr=pc. Hold until mem_ready, then IR<=mem_rdata, pc<=pc+4, go to DECODE.
- State DECODE: A<=rs, B<=rt, tgt<=(pc)+(sext(imm)<<2), where pc is already incremented. Illegal instruction -> TRAP. Otherwise -> EXEC.
- State EXEC:
  - R-type / addi: ALUOut<=result -> WB. Arithmetic wraps mod 2^32, no overflow trap. slt is signed.
  - lw/sw: ALUOut<=A+sext(imm). If unaligned and TRAP_ON_UNALIGNED=1 -> TRAP; otherwise -> MEM.
  - beq: if A==B then pc<=tgt. retire=1 -> FETCH.
  - j: pc<={pc[31:28], IR[25:0], 2'b00}. retire=1 -> FETCH.
- State MEM: mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B. Hold until mem_ready.
  - sw: retire=1 -> FETCH.
  - lw: MDR<=mem_rdata -> WB.
- State WB: write rd (R-type) or rt (addi/lw). retire=1 -> FETCH.
- Register file: writes to r0 are discarded; r0 always reads 0.
- State TRAP: mem_req=0, halted=1, pc frozen. Only nreset exits.
- Latency with zero-wait memory (mem_ready tied 1), in cycles: R/addi 4, lw 5, sw 4, beq 3, j 3. Each wait cycle adds 1.
- mem_req, mem_we, mem_addr and mem_wdata hold stable while waiting. The core never drops a request before ready.
- retire is asserted in the final cycle of an instruction, concurrent with its pc/register update.
- Reset asserted mid-transaction (any state, including waiting in MEM) aborts immediately. No write is issued after nreset falls. Restart is at RESET_PC.
- A store to address X followed by a fetch from X observes the new data (single port, strictly ordered).

Decomposition:
- Package mc_cpu_pkg:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J) and funct constants.
  - state enum {FETCH, DECODE, EXEC, MEM, WB, TRAP}.
  - 4-bit ALU mode constants.
- One sub-module, mc_regfile: 32x32, two async read ports, one sync write port, r0 hardwired to 0.
- The ALU stays inline as a case statement.

Test Plan:
- Reset: hold nreset=0 for 3 cycles with RESET_PC=32'h100 -> pc=32'h100, mem_req=0, halted=0. After release, first mem_addr=32'h100.
- Arithmetic: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1 with zero-wait memory -> r3=2, r4=1. Four retire pulses, 4 cycles apart.
- Memory with waits: sw r1,8(r0) then lw r5,8(r0); mem_ready low 2 cycles per transaction -> r5=5. Request signals stable during wait. sw takes 4+2+2 cycles.
- Control flow:
  - beq r0,r0,+2 at 0x0 -> next fetch at 0xC.
  - beq not taken -> next fetch at 0x4.
  - j 0x40 -> next fetch at 0x100.
- Traps:
  - opcode 6'h3F -> halted=1, mem_req stays 0, no retire.
  - lw with address 0x6 -> halted=1 (TRAP_ON_UNALIGNED=1).
- Reset mid-op: assert nreset during a sw MEM wait -> no write observed. Core refetches from RESET_PC.
